// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the IFU/LSU memory arbiter.
//                FSM state enum, requester id enum, RISC-V load/store funct3
//                encodings and the fixed funct3 used for instruction fetches.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester identity
    typedef enum logic [0:0] {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

    // RISC-V load funct3 encodings
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } f3Ld;

    // RISC-V store funct3 encodings
    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } f3St;

    // Instruction fetch is always a word load
    localparam logic [2:0] FETCH_FUNCT3 = LW;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_align_chk.sv
`default_nettype none
// ============================================================================
//  Module      : mem_align_chk
//  Description : Combinational misalignment check for one requester.
//                Halfword accesses need addr[0]=0, word accesses need
//                addr[1:0]=0, byte accesses are always aligned. Any funct3
//                that is not a legal load/store encoding is flagged too.
//  Ports       : i_store    - 1 = store encoding, 0 = load encoding
//                i_funct3   - RISC-V load/store funct3
//                i_addr_lo  - byte address bits [1:0]
//                o_misalign - access must be rejected
//  Revision    : 1.0  initial release
// ============================================================================
module mem_align_chk
    import mem_arb_pkg::*;
(
    input  logic       i_store,
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr_lo,
    output logic       o_misalign
);

    always_comb begin
        o_misalign = 1'b1;
        if (i_store) begin
            case (i_funct3)
                SB:      o_misalign = 1'b0;
                SH:      o_misalign = i_addr_lo[0];
                SW:      o_misalign = (i_addr_lo != 2'b00);
                default: o_misalign = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                LB, LBU: o_misalign = 1'b0;
                LH, LHU: o_misalign = i_addr_lo[0];
                LW:      o_misalign = (i_addr_lo != 2'b00);
                default: o_misalign = 1'b1;
            endcase
        end
    end

endmodule : mem_align_chk
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the single-port RAM between the instruction fetch
//                unit (IFU) and the load/store unit (LSU). One access at a
//                time goes through IDLE -> ACCESS -> RESP; a new grant may be
//                issued in RESP, giving one access every two cycles.
//                Misaligned requests are answered with err and never reach
//                the RAM.
//  Config      : MEM_ARB_RR_EN defined   -> round-robin on simultaneous
//                                           requests
//                MEM_ARB_RR_EN undefined -> fixed priority, LSU over IFU
//  Ports       : clk, rst (asynchronous, active-low)
//                ifu_req/addr -> ifu_gnt, ifu_rvalid/rdata/err
//                lsu_req/store/funct3/addr/wdata -> lsu_gnt,
//                                                   lsu_rvalid/rdata/err
//                ram_funct3/load/store/addr/wdata -> RAM, ram_rdata <- RAM
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // instruction fetch port
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    // load/store port
    input  logic        lsu_req,
    input  logic        lsu_store,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    // RAM port
    output logic [2:0]  ram_funct3,
    output logic        ram_load,
    output logic        ram_store,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;

    // latched request
    req_id_t     r_id;
    logic [2:0]  r_funct3;
    logic        r_store;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // response register
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_ifu_mis;
    logic        w_lsu_mis;
    logic        w_can_grant;
    logic        w_ifu_gnt;
    logic        w_lsu_gnt;
    logic        w_any_gnt;
    logic        w_in_access;
    logic        w_in_resp;

    // ------------------------------------------------------------------------
    // Alignment checks
    // ------------------------------------------------------------------------
    mem_align_chk u_ifu_chk (
        .i_store    (1'b0),
        .i_funct3   (FETCH_FUNCT3),
        .i_addr_lo  (ifu_addr[1:0]),
        .o_misalign (w_ifu_mis)
    );

    mem_align_chk u_lsu_chk (
        .i_store    (lsu_store),
        .i_funct3   (lsu_funct3),
        .i_addr_lo  (lsu_addr[1:0]),
        .o_misalign (w_lsu_mis)
    );

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    // Requester served by the most recent grant; starts as IFU so that the
    // first contested grant goes to the LSU.
    req_id_t r_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= REQ_IFU;
        end else if (w_lsu_gnt) begin
            r_last <= REQ_LSU;
        end else if (w_ifu_gnt) begin
            r_last <= REQ_IFU;
        end
    end
`endif

    // rst is included so that no grant escapes while reset is held
    assign w_can_grant = rst && ((r_state == IDLE) || (r_state == RESP));

    always_comb begin
        w_lsu_gnt = 1'b0;
        w_ifu_gnt = 1'b0;
        if (w_can_grant) begin
`ifdef MEM_ARB_RR_EN
            if (lsu_req && ifu_req) begin
                if (r_last == REQ_IFU) begin
                    w_lsu_gnt = 1'b1;
                end else begin
                    w_ifu_gnt = 1'b1;
                end
            end else begin
                w_lsu_gnt = lsu_req;
                w_ifu_gnt = ifu_req;
            end
`else
            w_lsu_gnt = lsu_req;
            w_ifu_gnt = ifu_req && !lsu_req;
`endif
        end
    end

    assign w_any_gnt = w_lsu_gnt || w_ifu_gnt;
    assign lsu_gnt   = w_lsu_gnt;
    assign ifu_gnt   = w_ifu_gnt;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_any_gnt ? ACCESS : IDLE;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = w_any_gnt ? ACCESS : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch and response capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id       <= REQ_IFU;
            r_funct3   <= 3'b000;
            r_store    <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rsp_data <= 32'h0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_lsu_gnt) begin
                r_id     <= REQ_LSU;
                r_funct3 <= lsu_funct3;
                r_store  <= lsu_store;
                r_err    <= w_lsu_mis;
                r_addr   <= lsu_addr;
                r_wdata  <= lsu_wdata;
            end else if (w_ifu_gnt) begin
                // fetches leave the write data register untouched
                r_id     <= REQ_IFU;
                r_funct3 <= FETCH_FUNCT3;
                r_store  <= 1'b0;
                r_err    <= w_ifu_mis;
                r_addr   <= ifu_addr;
            end
            if (r_state == ACCESS) begin
                r_rsp_data <= (r_store || r_err) ? 32'h0 : ram_rdata;
                r_rsp_err  <= r_err;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign w_in_access = (r_state == ACCESS);
    assign w_in_resp   = (r_state == RESP);

    // Strobes follow the asynchronously reset state, so a reset in ACCESS
    // removes ram_store before the committing edge.
    assign ram_load   = w_in_access && !r_store && !r_err;
    assign ram_store  = w_in_access &&  r_store && !r_err;
    assign ram_funct3 = r_funct3;
    assign ram_addr   = r_addr;
    assign ram_wdata  = r_wdata;

    assign ifu_rvalid = w_in_resp && (r_id == REQ_IFU);
    assign lsu_rvalid = w_in_resp && (r_id == REQ_LSU);
    assign ifu_rdata  = ifu_rvalid ? r_rsp_data : 32'h0;
    assign lsu_rdata  = lsu_rvalid ? r_rsp_data : 32'h0;
    assign ifu_err    = ifu_rvalid && r_rsp_err;
    assign lsu_err    = lsu_rvalid && r_rsp_err;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a small
//                word-addressed RAM model (combinational read, write on the
//                rising edge while ram_store is high).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        ifu_err;
    logic        lsu_req;
    logic        lsu_store;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic [2:0]  ram_funct3;
    logic        ram_load;
    logic        ram_store;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ifu_req    (ifu_req),
        .ifu_addr   (ifu_addr),
        .ifu_gnt    (ifu_gnt),
        .ifu_rvalid (ifu_rvalid),
        .ifu_rdata  (ifu_rdata),
        .ifu_err    (ifu_err),
        .lsu_req    (lsu_req),
        .lsu_store  (lsu_store),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_gnt    (lsu_gnt),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .lsu_err    (lsu_err),
        .ram_funct3 (ram_funct3),
        .ram_load   (ram_load),
        .ram_store  (ram_store),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // RAM model with a backdoor preload port
    // ------------------------------------------------------------------------
    logic [31:0] mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;

    always_comb ram_rdata = mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (ram_store) begin
            case (ram_funct3)
                3'b010: mem[ram_addr[9:2]] <= ram_wdata;
                3'b001: begin
                    if (ram_addr[1]) mem[ram_addr[9:2]][31:16] <= ram_wdata[15:0];
                    else             mem[ram_addr[9:2]][15:0]  <= ram_wdata[15:0];
                end
                default: mem[ram_addr[9:2]][ram_addr[1:0]*8 +: 8] <= ram_wdata[7:0];
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        bd_idx  = idx;
        bd_data = data;
        bd_we   = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic lsu_drive(input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        lsu_req    = 1'b1;
        lsu_store  = st;
        lsu_funct3 = f3;
        lsu_addr   = a;
        lsu_wdata  = wd;
    endtask

    initial begin
        rst        = 1'b0;
        bd_we      = 1'b0;
        bd_idx     = 8'h0;
        bd_data    = 32'h0;
        ifu_req    = 1'b0;
        ifu_addr   = 32'h0;
        lsu_req    = 1'b0;
        lsu_store  = 1'b0;
        lsu_funct3 = 3'b000;
        lsu_addr   = 32'h0;
        lsu_wdata  = 32'h0;

        // preload while reset holds the arbiter quiet
        preload(8'd5,  32'h1234_5678);
        preload(8'd8,  32'hCAFE_F00D);
        preload(8'd12, 32'hAAAA_5555);

        // ---------------- reset values ----------------
        chk("rst_ifu_gnt",    ifu_gnt,    0);
        chk("rst_lsu_rvalid", lsu_rvalid, 0);
        chk("rst_ifu_rvalid", ifu_rvalid, 0);
        chk("rst_lsu_rdata",  lsu_rdata,  0);
        chk("rst_ram_load",   ram_load,   0);
        chk("rst_ram_store",  ram_store,  0);
        chk("rst_ram_addr",   ram_addr,   0);
        chk("rst_ram_funct3", ram_funct3, 0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- SW 0x10 then LW 0x10 ----------------
        next_cycle();
        lsu_drive(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        #1;
        chk("sw_lsu_gnt", lsu_gnt, 1);
        chk("sw_ifu_gnt", ifu_gnt, 0);
        next_cycle();                              // ACCESS
        lsu_req = 1'b0;
        chk("sw_ram_store", ram_store, 1);
        chk("sw_ram_addr",  ram_addr,  32'h10);
        chk("sw_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("sw_access_gnt", lsu_gnt, 0);
        next_cycle();                              // RESP
        chk("sw_rvalid", lsu_rvalid, 1);
        chk("sw_rdata",  lsu_rdata,  0);
        chk("sw_err",    lsu_err,    0);
        chk("sw_mem",    mem[4],     32'hDEAD_BEEF);
        lsu_drive(1'b0, 3'b010, 32'h10, 32'h0);    // back-to-back in RESP
        #1;
        chk("lw_gnt_in_resp", lsu_gnt, 1);
        next_cycle();                              // ACCESS
        lsu_req = 1'b0;
        chk("lw_ram_load",  ram_load,  1);
        chk("lw_ram_store", ram_store, 0);
        next_cycle();                              // RESP
        chk("lw_rvalid", lsu_rvalid, 1);
        chk("lw_rdata",  lsu_rdata,  32'hDEAD_BEEF);
        next_cycle();                              // IDLE

        // ---------------- simultaneous IFU LW 0x10 / LSU LW 0x14 ----------------
        lsu_drive(1'b0, 3'b010, 32'h14, 32'h0);
        ifu_req  = 1'b1;
        ifu_addr = 32'h10;
        #1;
        chk("sim_lsu_gnt", lsu_gnt, 1);
        chk("sim_ifu_gnt", ifu_gnt, 0);
        next_cycle();                              // T+1 ACCESS
        lsu_req = 1'b0;
        chk("sim_ifu_gnt_access", ifu_gnt, 0);
        next_cycle();                              // T+2 RESP
        chk("sim_lsu_rvalid", lsu_rvalid, 1);
        chk("sim_lsu_rdata",  lsu_rdata,  32'h1234_5678);
        chk("sim_ifu_rvalid_early", ifu_rvalid, 0);
        chk("sim_ifu_gnt_resp", ifu_gnt, 1);
        next_cycle();                              // T+3 ACCESS
        ifu_req = 1'b0;
        chk("sim_ifu_ram_load", ram_load, 1);
        chk("sim_ifu_ram_addr", ram_addr, 32'h10);
        chk("sim_ifu_ram_f3",   ram_funct3, 3'b010);
        next_cycle();                              // T+4 RESP
        chk("sim_ifu_rvalid", ifu_rvalid, 1);
        chk("sim_ifu_rdata",  ifu_rdata,  32'hDEAD_BEEF);
        chk("sim_lsu_rvalid_off", lsu_rvalid, 0);
        next_cycle();

        // ---------------- misaligned SH 0x21 ----------------
        lsu_drive(1'b1, 3'b001, 32'h21, 32'h0000_BEEF);
        #1;
        chk("sh_gnt", lsu_gnt, 1);
        next_cycle();
        lsu_req = 1'b0;
        chk("sh_ram_store", ram_store, 0);
        next_cycle();
        chk("sh_rvalid", lsu_rvalid, 1);
        chk("sh_err",    lsu_err,    1);
        chk("sh_rdata",  lsu_rdata,  0);
        chk("sh_mem",    mem[8],     32'hCAFE_F00D);
        next_cycle();

        // ---------------- misaligned fetch 0x102 ----------------
        ifu_req  = 1'b1;
        ifu_addr = 32'h102;
        #1;
        chk("if_gnt", ifu_gnt, 1);
        next_cycle();
        ifu_req = 1'b0;
        chk("if_ram_load", ram_load, 0);
        next_cycle();
        chk("if_rvalid", ifu_rvalid, 1);
        chk("if_err",    ifu_err,    1);
        chk("if_rdata",  ifu_rdata,  0);
        next_cycle();

        // ---------------- reset during ACCESS of SW 0x30 ----------------
        lsu_drive(1'b1, 3'b010, 32'h30, 32'h1111_1111);
        #1;
        chk("rs_gnt", lsu_gnt, 1);
        next_cycle();                              // ACCESS, req left high
        chk("rs_ram_store_pre", ram_store, 1);
        #2 rst = 1'b0;
        #1;
        chk("rs_ram_store_async", ram_store, 0);
        chk("rs_gnt_in_reset",    lsu_gnt,   0);
        next_cycle();
        chk("rs_mem",       mem[12],    32'hAAAA_5555);
        chk("rs_rvalid",    lsu_rvalid, 0);
        chk("rs_ram_addr",  ram_addr,   0);
        chk("rs_ram_wdata", ram_wdata,  0);
        chk("rs_ram_load",  ram_load,   0);
        chk("rs_gnt_held",  lsu_gnt,    0);
        lsu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // ---------------- both requesters held for 8 cycles ----------------
        next_cycle();
        lsu_drive(1'b0, 3'b010, 32'h14, 32'h0);
        ifu_req  = 1'b1;
        ifu_addr = 32'h10;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] exp_g;
            #1;
            if (i % 2 == 1)       exp_g = 2'b00;
`ifdef MEM_ARB_RR_EN
            else if (i % 4 == 0)  exp_g = 2'b10;   // LSU
            else                  exp_g = 2'b01;   // IFU
`else
            else                  exp_g = 2'b10;   // LSU always wins
`endif
            chk($sformatf("arb_cyc%0d", i), {lsu_gnt, ifu_gnt}, exp_g);
            next_cycle();
        end
        lsu_req = 1'b0;
        ifu_req = 1'b0;
        next_cycle();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester controller that shares the single-port data/instruction RAM between the instruction-fetch unit (IFU) and the load/store unit (LSU). Grants one access at a time, sequences it through a fixed three-state FSM, drives the RAM's funct3/load/store/addr/wdata inputs from a registered request, and returns registered read data to the winner. Misaligned accesses are rejected without touching the RAM.

## Interface
Parameters:
- none; RAM geometry is owned by the RAM itself.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (low = reset).
- ifu_req  in  1  fetch request; held with ifu_addr until ifu_gnt.
- ifu_addr  in  32  fetch byte address; fetch is always a word load.
- ifu_gnt  out  1  request accepted this cycle (combinational).
- ifu_rvalid  out  1  one-cycle response pulse.
- ifu_rdata  out  32  fetched word, valid with ifu_rvalid.
- ifu_err  out  1  misaligned fetch, valid with ifu_rvalid.
- lsu_req  in  1  data request; held with payload until lsu_gnt.
- lsu_store  in  1  1 = store, 0 = load.
- lsu_funct3  in  3  RISC-V load/store funct3.
- lsu_addr  in  32  byte address.
- lsu_wdata  in  32  store data, unshifted.
- lsu_gnt  out  1  request accepted this cycle (combinational).
- lsu_rvalid  out  1  one-cycle response pulse (loads and stores).
- lsu_rdata  out  32  load result as returned by RAM; 0 for stores/errors.
- lsu_err  out  1  misaligned access, valid with lsu_rvalid.
- ram_funct3  out  3  to RAM.
- ram_load  out  1  to RAM.
- ram_store  out  1  to RAM.
- ram_addr  out  32  to RAM.
- ram_wdata  out  32  to RAM.
- ram_rdata  in  32  from RAM, combinational read.

## Operation
- FSM states: IDLE, ACCESS, RESP. IDLE→ACCESS on any grant; ACCESS→RESP always; RESP→ACCESS on grant, else IDLE.
- Grants only in IDLE or RESP, at most one gnt per cycle, never while rst low.
- Arbitration (default): fixed priority, LSU over IFU.
- On grant: latch requester id, funct3 (IFU: LW = 3'b010), load/store, addr, wdata, err flag.
- Misalign: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; fetch with addr[1:0]≠0. Illegal lsu_funct3 treated as misaligned.
- ACCESS: ram_load/ram_store asserted from latch only if err flag clear; ram_rdata captured into response register (0 if store or err).
- RESP: winner's rvalid=1 with rdata/err; other requester's rvalid=0. No response back-pressure.
- ram_load/ram_store are 0 in IDLE and RESP; ram_addr/funct3/wdata hold last latched values.

## Timing
- Request at cycle T with gnt → RAM access at T+1 (store written at end of T+1) → rvalid at T+2.
- Back-to-back: new grant allowed in RESP cycle; throughput one access per 2 cycles.
- Requester may drop req the cycle after gnt; req not granted must stay high with stable payload.
- Reset values: state IDLE, all gnt/rvalid/err 0, rdata 0, ram_load/ram_store 0, ram_addr/ram_wdata 0, ram_funct3 0, RR pointer = "last served IFU".
- Reset asserted mid-ACCESS: ram_store drops asynchronously, write not committed if rst low at the edge; pending response discarded.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not served last wins; pointer updates on every grant. Single requester always wins.
- Undefined: fixed LSU-over-IFU priority; pointer logic absent.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE/ACCESS/RESP), requester id enum (REQ_IFU/REQ_LSU), FETCH_FUNCT3 constant; funct3 encodings reused from existing f3Ld/f3St.
- Sub-module mem_align_chk: combinational funct3/addr[1:0] → misalign flag, instanced for both requesters.

## Test plan
- Single LSU SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 → store gnt T, lsu_rvalid T+2; load lsu_rdata 0xDEADBEEF.
- Simultaneous IFU LW 0x10 and LSU LW 0x14 in IDLE → LSU granted first, IFU granted in RESP cycle, ifu_rdata 0xDEADBEEF at T+4.
- With MEM_ARB_RR_EN, both held high for 8 cycles → grants alternate LSU, IFU, LSU, IFU; no starvation.
- LSU SH addr 0x21 → lsu_err=1 at T+2, ram_store never asserted, mem word 0x20 unchanged.
- IFU fetch addr 0x102 → ifu_err=1, ifu_rdata 0, ram_load never asserted.
- rst pulled low during ACCESS of SW 0x30 → ram_store 0 immediately, word 0x30 unchanged, all outputs at reset values, FSM IDLE.
